// File: rtl/sqrt_float_dispatch.sv
// Operand FIFO, special-value bypass and start/done sequencer for the CORDIC float sqrt core.
// Optional core watchdog (adds out_timeout) enabled by defining SQRT_DISP_WDOG_EN.
`timescale 1ns/1ps
module sqrt_float_dispatch #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        core_start,
  output logic [31:0] core_u,
  input  logic [31:0] core_out,
  input  logic        core_done,
  input  logic        core_neg_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_bypass,
`ifdef SQRT_DISP_WDOG_EN
  output logic        out_timeout,
`endif
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] PINF    = 32'h7F80_0000;

  typedef enum logic [2:0] {S_IDLE, S_CLASS, S_ISSUE, S_WAIT, S_HOLD} state_t;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [31:0]   op_q, op_d;
  logic [31:0]   core_u_q, core_u_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          inv_q, inv_d;
  logic          byp_q, byp_d;

`ifdef SQRT_DISP_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          tmo_q, tmo_d;
`endif

  logic       op_s;
  logic [7:0] op_e;
  logic       op_f_nz;

  assign op_s    = op_q[31];
  assign op_e    = op_q[30:23];
  assign op_f_nz = |op_q[22:0];

  assign in_ready   = (cnt_q < DEPTH_C);
  assign push       = in_valid & in_ready;
  assign core_start = (state_q == S_ISSUE);
  assign out_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
  assign core_u     = core_u_q;
  assign out_data   = out_data_q;
  assign out_invalid = inv_q;
  assign out_bypass = byp_q;
`ifdef SQRT_DISP_WDOG_EN
  assign out_timeout = tmo_q;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    core_u_d   = core_u_q;
    out_data_d = out_data_q;
    inv_d      = inv_q;
    byp_d      = byp_q;
    pop        = 1'b0;
`ifdef SQRT_DISP_WDOG_EN
    wdog_d     = wdog_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          op_d    = mem_q[rd_ptr_q];
          state_d = S_CLASS;
        end
      end
      S_CLASS: begin
        // Special operands never reach the core; their result is final here.
        state_d = S_HOLD;
        byp_d   = 1'b1;
        inv_d   = 1'b0;
`ifdef SQRT_DISP_WDOG_EN
        tmo_d   = 1'b0;
`endif
        if (op_e == 8'hFF) begin
          if (op_f_nz || op_s) begin
            out_data_d = QNAN;
            inv_d      = 1'b1;
          end else begin
            out_data_d = PINF;
          end
        end else if (op_e == 8'h00) begin
          out_data_d = {op_s, 31'b0};
        end else if (op_s) begin
          out_data_d = QNAN;
          inv_d      = 1'b1;
        end else begin
          byp_d      = byp_q;
          inv_d      = inv_q;
`ifdef SQRT_DISP_WDOG_EN
          tmo_d      = tmo_q;
`endif
          core_u_d   = op_q;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef SQRT_DISP_WDOG_EN
        wdog_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          out_data_d = core_out;
          inv_d      = core_neg_flag;
          byp_d      = 1'b0;
`ifdef SQRT_DISP_WDOG_EN
          tmo_d      = 1'b0;
`endif
          state_d    = S_HOLD;
        end
`ifdef SQRT_DISP_WDOG_EN
        // Counter reaches WDOG_CYCLES on this cycle: the WDOG_CYCLES-th WAIT cycle without done.
        else if (wdog_q == WDOG_LAST) begin
          out_data_d = QNAN;
          inv_d      = 1'b1;
          byp_d      = 1'b0;
          tmo_d      = 1'b1;
          state_d    = S_HOLD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      core_u_q   <= '0;
      out_data_q <= '0;
      inv_q      <= 1'b0;
      byp_q      <= 1'b0;
`ifdef SQRT_DISP_WDOG_EN
      wdog_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      core_u_q   <= core_u_d;
      out_data_q <= out_data_d;
      inv_q      <= inv_d;
      byp_q      <= byp_d;
`ifdef SQRT_DISP_WDOG_EN
      wdog_q     <= wdog_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_sqrt_float_dispatch.sv
// Directed and randomized bench for sqrt_float_dispatch with a behavioural core model
// and an in-order result scoreboard.
`timescale 1ns/1ps
module tb_sqrt_float_dispatch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WDOG  = 64;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        core_start;
  logic [31:0] core_u;
  logic [31:0] core_out;
  logic        core_done;
  logic        core_neg_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_bypass;
  logic        busy;
`ifdef SQRT_DISP_WDOG_EN
  logic        out_timeout;
`endif

  sqrt_float_dispatch #(.FIFO_DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .core_start   (core_start),
    .core_u       (core_u),
    .core_out     (core_out),
    .core_done    (core_done),
    .core_neg_flag(core_neg_flag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_invalid  (out_invalid),
    .out_bypass   (out_bypass),
`ifdef SQRT_DISP_WDOG_EN
    .out_timeout  (out_timeout),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
    logic        byp;
    logic        tmo;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] iss_q[$];
  res_t        mon_e;
  int unsigned ncmp = 0;
  int unsigned nerr = 0;
  int unsigned start_cnt = 0;
  int unsigned core_lat = 5;
  bit          lat_rand = 0;
  bit          core_stall = 0;
  int unsigned rdy_mode = 1;
  bit          pend = 0;
  int unsigned rem = 0;
  logic [31:0] cur_u = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    ncmp++;
    assert (got === expv) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Stand-in core: halves the biased exponent around 127 and halves the fraction.
  function automatic logic [31:0] core_fn(input logic [31:0] u);
    int unsigned ee;
    int unsigned ne;
    ee = int'(u[30:23]);
    ne = (ee + 127) / 2;
    return {1'b0, ne[7:0], 1'b0, u[22:1]};
  endfunction

  function automatic res_t model(input logic [31:0] x);
    res_t r;
    r.tmo = 1'b0;
    r.byp = 1'b1;
    r.inv = 1'b0;
    if (x[30:23] == 8'd255) begin
      if (x[22:0] != 0 || x[31]) begin r.data = 32'h7FC00000; r.inv = 1'b1; end
      else r.data = 32'h7F800000;
    end else if (x[30:23] == 8'd0) begin
      r.data = x & 32'h80000000;
    end else if (x[31]) begin
      r.data = 32'h7FC00000; r.inv = 1'b1;
    end else begin
      r.data = core_fn(x);
      r.byp  = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom();
    e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 6))
      0, 1: r = {1'b0, e, r[22:0]};
      2:    r = {1'b1, e, r[22:0]};
      3:    r = {r[31], 31'b0};
      4:    r = {r[31], 8'd0, r[22:0] | 23'd1};
      5:    r = {r[31], 8'hFF, 23'd0};
      default: r = {r[31], 8'hFF, r[22:0] | 23'd1};
    endcase
    return r;
  endfunction

  task automatic send(input logic [31:0] d);
    int unsigned n;
    res_t r;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      ncmp++; nerr++;
      $error("FAIL send_timeout: got in_ready=0 expected in_ready=1 for %h", d);
      in_valid = 1'b0;
      return;
    end
    r = model(d);
    exp_q.push_back(r);
    if (!r.byp) iss_q.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned bound);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // Core model: answers each start after the configured latency.
  initial begin
    core_done = 1'b0; core_out = '0; core_neg_flag = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (pend && !core_stall) begin
          rem--;
          if (rem == 0) begin
            chk("core_u_hold", core_u, cur_u);
            core_done = 1'b1;
            core_out = core_fn(cur_u);
            core_neg_flag = cur_u[31];
            pend = 0;
          end
        end
        if (core_start) begin
          start_cnt++;
          if (iss_q.size() == 0) begin
            ncmp++; nerr++;
            $error("FAIL core_start_unexpected: got start with u=%h expected none", core_u);
          end else begin
            cur_u = iss_q.pop_front();
            chk("core_u", core_u, cur_u);
          end
          pend = 1;
          rem = lat_rand ? $urandom_range(1, 12) : core_lat;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        ncmp++; nerr++;
        $error("FAIL out_unexpected: got %h expected no result", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_invalid", 32'(out_invalid), 32'(mon_e.inv));
        chk("out_bypass", 32'(out_bypass), 32'(mon_e.byp));
`ifdef SQRT_DISP_WDOG_EN
        chk("out_timeout", 32'(out_timeout), 32'(mon_e.tmo));
`endif
      end
    end
  end

  initial begin
    int unsigned s0;
    int unsigned n;
    logic [31:0] ops [DEPTH+2];

    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_core_u", core_u, 32'd0);
    chk("rst_flags", {30'd0, out_invalid, out_bypass}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 4.0 through the core, 20-cycle latency
    core_lat = 20; s0 = start_cnt;
    send(32'h40800000);
    drain(200);
    chk("t1_starts", start_cnt - s0, 1);

    // -1.0 bypass latency
    s0 = start_cnt;
    send(32'hBF800000);
    @(negedge clk); chk("t2_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("t2_valid_c2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("t2_valid_c3", 32'(out_valid), 32'd1);
    drain(50);
    chk("t2_starts", start_cnt - s0, 0);

    // back-to-back specials
    s0 = start_cnt;
    send(32'h7F800000);
    send(32'h80000000);
    send(32'h00000001);
    send(32'h7FC12345);
    drain(100);
    chk("t3_starts", start_cnt - s0, 0);

    // backpressure: FIFO plus HOLD fill, nothing lost
    lat_rand = 1; rdy_mode = 0;
    repeat (2) @(negedge clk);
    foreach (ops[i]) ops[i] = rand_op();
    for (int i = 0; i < DEPTH + 1; i++) send(ops[i]);
    repeat (60) @(negedge clk);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    chk("t4_hold_valid", 32'(out_valid), 32'd1);
    chk("t4_hold_data", out_data, model(ops[0]).data);
    chk("t4_queued", exp_q.size(), DEPTH + 1);
    rdy_mode = 1;
    send(ops[DEPTH+1]);
    drain(500);

    // reset while waiting on the core
    lat_rand = 0; core_lat = 40; s0 = start_cnt;
    send(32'h40800000);
    n = 0;
    while (start_cnt == s0 && n < 50) begin @(negedge clk); n++; end
    chk("t5_started", start_cnt - s0, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_core_start", 32'(core_start), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_out_data", out_data, 32'd0);
    chk("t5_core_u", core_u, 32'd0);
    chk("t5_flags", {30'd0, out_invalid, out_bypass}, 32'd0);
    exp_q.delete(); iss_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    core_lat = 20;
    send(32'h40800000);
    drain(200);

    // randomized stream with random core latency and downstream stalls
    lat_rand = 1; rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand_op());
    end
    drain(3000);
    rdy_mode = 1;

`ifdef SQRT_DISP_WDOG_EN
    // stuck core: watchdog result
    core_stall = 1;
    send(32'h40800000);
    exp_q[exp_q.size()-1] = '{data: 32'h7FC00000, inv: 1'b1, byp: 1'b0, tmo: 1'b1};
    drain(WDOG + 50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/sqrt_float_dispatch.md
Name: sqrt_float_dispatch

Overview:
- Front-end and back-end sequencer for the iterative CORDIC float square-root core.
- Buffers IEEE-754 single-precision operands from a valid/ready stream in a small FIFO.
- Resolves special operands (NaN, ±inf, ±0, subnormal, negative) locally without using the core.
- For normal positive operands, drives the core's start/u handshake, captures out/done/neg_flag, and returns results in order on a valid/ready output stream.

Parameters:
- FIFO_DEPTH, 4: operand FIFO entries; power of two, ≥2.
- WDOG_CYCLES, 64: maximum cycles allowed in WAIT before a timeout result. Used only with SQRT_DISP_WDOG_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  high when FIFO count < FIFO_DEPTH.
- in_data  in  32  IEEE-754 operand.
- core_start  out  1  one-cycle start pulse to the sqrt core.
- core_u  out  32  operand to the core; held stable from ISSUE through WAIT.
- core_out  in  32  core result.
- core_done  in  1  core completion.
- core_neg_flag  in  1  core negative-input flag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  result.
- out_invalid  out  1  invalid-operation flag accompanying out_data.
- out_bypass  out  1  result was produced without the core.
- busy  out  1  high whenever FSM ≠ IDLE or FIFO is non-empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied, FSM → IDLE.
  - in_ready=1; core_start, out_valid, out_invalid, out_bypass, busy = 0.
  - core_u and out_data = 0.
  - Reset in any state aborts the operation. A result in HOLD is discarded. The core shares the same reset domain.
- FIFO:
  - Push when in_valid & in_ready; pop only in IDLE.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - in_ready is combinational from the registered count. A pop does not raise in_ready in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: if FIFO is non-empty, pop the head into op_r and go to CLASS.
- FSM CLASS: classify op_r (s = sign, e = exponent, f = fraction).
  - e=255, f≠0 → 0x7FC00000, invalid=1; go to HOLD.
  - +inf → 0x7F800000, invalid=0; go to HOLD.
  - -inf → 0x7FC00000, invalid=1; go to HOLD.
  - e=0 (zero or subnormal, flushed) → {s, 31'b0}, invalid=0; go to HOLD.
  - s=1, otherwise normal → 0x7FC00000, invalid=1; go to HOLD.
  - Every case above sets bypass=1.
  - Any other operand → go to ISSUE.
- FSM ISSUE: core_start=1 for exactly this cycle, core_u=op_r; go to WAIT.
- FSM WAIT:
  - On the first cycle core_done=1: latch out_data=core_out, out_invalid=core_neg_flag, out_bypass=0; go to HOLD.
  - core_done in any state other than WAIT is ignored.
- FSM HOLD:
  - out_valid=1; out_data and flags are stable.
  - When out_ready=1, the transfer completes and the FSM returns to IDLE; out_valid drops next cycle.
- Latency (FIFO empty, FSM IDLE, accept at cycle 0):
  - Pop at cycle 1, CLASS at cycle 2.
  - Bypass result: out_valid at cycle 3.
  - Core path: core_start at cycle 3; out_valid one cycle after core_done is seen.
- Ordering: results leave strictly in operand order; one operation in flight.
- Throughput: one result per transfer + 3 cycles (bypass path).

Optional Feature:
- Macro: SQRT_DISP_WDOG_EN.
- Defined:
  - Adds output port out_timeout (1 bit).
  - A counter of width $clog2(WDOG_CYCLES+1) clears in ISSUE and increments in WAIT.
  - If it reaches WDOG_CYCLES without core_done: out_data=0x7FC00000, out_invalid=1, out_bypass=0, out_timeout=1; go to HOLD.
  - out_timeout=0 on every other result; reset value 0.
- Undefined: no port and no counter; WAIT lasts indefinitely until core_done.

Test Plan:
- 0x40800000 (4.0), core model returns 0x40000000 after 20 cycles → exactly one core_start pulse with core_u=0x40800000; out_data=0x40000000, invalid=0, bypass=0.
- 0xBF800000 (-1.0) → no core_start; out_valid at cycle 3 with 0x7FC00000, invalid=1, bypass=1.
- 0x7F800000, 0x80000000, 0x00000001, 0x7FC12345 streamed back-to-back → in order: 0x7F800000 (invalid 0), 0x80000000 (invalid 0), 0x00000000 (invalid 0), 0x7FC00000 (invalid 1); all with bypass=1 and core_start never asserted.
- out_ready held 0 while FIFO_DEPTH+2 operands are offered → in_ready=0 after the FIFO fills; no operand is lost or duplicated; releasing out_ready drains all results in order.
- rst pulsed low during WAIT → all outputs reach reset values immediately; busy=0; a later 4.0 request completes normally.
- With SQRT_DISP_WDOG_EN and core_done tied 0 → after WDOG_CYCLES cycles in WAIT: out_data=0x7FC00000, invalid=1, out_timeout=1.
